// File: rtl/pattern_pkg.sv
// Shared definitions for the sync-pattern link: the sync word used by both ends
// and the transmitter state encoding.
package pattern_pkg;

    localparam int                SYNC_W   = 5;
    localparam logic [SYNC_W-1:0] SYNC_PAT = 5'b10010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pattern_tx_bit_timer.sv
// Bit-period divider: one-cycle o_tick at the end of each CLKS_PER_BIT-cycle
// bit period, realigned to zero on i_restart.
module bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    input  logic i_run,
    output logic o_tick
);
    import pattern_pkg::*;

    localparam int            CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_restart)
            r_cnt <= '0;
        else if (i_run)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end

    assign o_tick = i_run && (r_cnt == LAST);

endmodule

// File: rtl/pattern_tx.sv
// Serial frame transmitter: sync word, payload MSB-first, then GAP_BITS zeros,
// one bit per CLKS_PER_BIT cycles on a registered line.
module pattern_tx #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = pattern_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT     = pattern_pkg::SYNC_PAT,
    parameter int                GAP_BITS     = 2,
    parameter int                CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sig,
    output logic              busy,
    output logic              done
);
    import pattern_pkg::*;

    localparam int SH_W    = SYNC_W + DATA_W;
    localparam int LEN_MAX = (SYNC_W > DATA_W) ? ((SYNC_W > GAP_BITS) ? SYNC_W : GAP_BITS)
                                               : ((DATA_W > GAP_BITS) ? DATA_W : GAP_BITS);
    localparam int BW      = cnt_w(LEN_MAX);
    localparam logic [BW-1:0] SYNC_END = BW'(SYNC_W - 1);
    localparam logic [BW-1:0] DATA_END = BW'(DATA_W - 1);
    localparam logic [BW-1:0] GAP_END  = BW'(GAP_BITS - 1);

    tx_state_e       r_state, w_state_nxt;
    logic [SH_W-1:0] r_sh;
    logic [BW-1:0]   r_bcnt;
    logic            r_done;
    logic            w_tick, w_last, w_accept, w_busy;

    assign in_ready = (r_state == IDLE);
    assign w_busy   = (r_state != IDLE);
    assign w_accept = in_ready && in_valid;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_accept),
        .i_run     (w_busy),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        case (r_state)
            IDLE: if (in_valid) w_state_nxt = SYNC;
            SYNC: begin
                w_last = (r_bcnt == SYNC_END);
                if (w_tick && w_last) w_state_nxt = DATA;
            end
            DATA: begin
                w_last = (r_bcnt == DATA_END);
                if (w_tick && w_last) w_state_nxt = GAP;
            end
            GAP: begin
                w_last = (r_bcnt == GAP_END);
                if (w_tick && w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Sync and payload share one shifter; zero fill makes the gap bits and the
    // idle level fall out of the same shift with no extra mux on sig.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_bcnt <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_tick && w_last && (r_state == GAP);
            if (w_accept) begin
                r_sh   <= {SYNC_PAT, in_data};
                r_bcnt <= '0;
            end else if (w_tick) begin
                r_sh   <= {r_sh[SH_W-2:0], 1'b0};
                r_bcnt <= w_last ? '0 : r_bcnt + 1'b1;
            end
        end
    end

    assign sig  = r_sh[SH_W-1];
    assign busy = w_busy;
    assign done = r_done;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: one instance at 1 clock/bit with a sync-word
// detector on its line, one at 4 clocks/bit.
module tb_pattern_tx;

    localparam logic [4:0] SW = 5'b10010;

    logic       clk, rst_n;
    logic       v1, v4;
    logic [7:0] dat1, dat4;
    logic       rdy1, sig1, busy1, done1;
    logic       rdy4, sig4, busy4, done4;

    int n_vec = 0;
    int n_err = 0;

    pattern_tx #(.CLKS_PER_BIT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(dat1),
        .in_ready(rdy1), .sig(sig1), .busy(busy1), .done(done1)
    );

    pattern_tx #(.CLKS_PER_BIT(4)) d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(dat4),
        .in_ready(rdy4), .sig(sig4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver-side sync detector fed straight from the 1-clock/bit line.
    logic [4:0] rx_sh = '0;
    logic       rx_match;
    always @(posedge clk) rx_sh <= {rx_sh[3:0], sig1};
    assign rx_match = (rx_sh == SW);

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame on d1 from IDLE and checks it bit by bit; returns in the
    // done cycle. mm[k] is the expected detector output at bit sample k.
    task automatic frame1(input logic [7:0] d, input logic [15:0] mm, input bit hold);
        logic [14:0] s;
        s    = {SW, d, 2'b00};
        v1   = 1'b1;
        dat1 = d;
        step(1);
        if (!hold) v1 = 1'b0;
        dat1 = ~d;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("d%02h sig k=%0d", d, k), sig1, s[14-k]);
            chk($sformatf("d%02h busy k=%0d", d, k), busy1, 1'b1);
            chk($sformatf("d%02h ready k=%0d", d, k), rdy1, 1'b0);
            chk($sformatf("d%02h done k=%0d", d, k), done1, 1'b0);
            chk($sformatf("d%02h match k=%0d", d, k), rx_match, mm[k]);
            step(1);
        end
        chk($sformatf("d%02h end done", d), done1, 1'b1);
        chk($sformatf("d%02h end busy", d), busy1, 1'b0);
        chk($sformatf("d%02h end ready", d), rdy1, 1'b1);
        chk($sformatf("d%02h end sig", d), sig1, 1'b0);
        chk($sformatf("d%02h end match", d), rx_match, mm[15]);
    endtask

    initial begin
        logic [14:0] s4;
        rst_n = 1'b1;
        v1 = 1'b0; dat1 = 8'h00;
        v4 = 1'b0; dat4 = 8'h00;

        // Reset asserted between edges takes effect immediately.
        #1 rst_n = 1'b0;
        v1 = 1'b1; dat1 = 8'hFF; v4 = 1'b1; dat4 = 8'hFF;
        #1;
        chk("rst sig1", sig1, 1'b0);
        chk("rst busy1", busy1, 1'b0);
        chk("rst done1", done1, 1'b0);
        chk("rst ready1", rdy1, 1'b1);
        chk("rst sig4", sig4, 1'b0);
        chk("rst ready4", rdy4, 1'b1);
        step(2);
        chk("rst held busy1", busy1, 1'b0);
        chk("rst held sig1", sig1, 1'b0);
        chk("rst held busy4", busy4, 1'b0);
        rst_n = 1'b1;
        v1 = 1'b0; v4 = 1'b0;
        step(2);
        chk("idle ready1", rdy1, 1'b1);

        // 8'hA5: stream and detector (second match comes from the payload).
        frame1(8'hA5, 16'h1020, 1'b0);
        step(1);
        chk("A5 done drops", done1, 1'b0);
        step(3);

        frame1(8'h00, 16'h0020, 1'b0);
        step(1);
        chk("00 done drops", done1, 1'b0);
        step(2);

        // 4 clocks per bit with input activity while busy.
        v4 = 1'b1; dat4 = 8'h3C;
        s4 = {SW, 8'h3C, 2'b00};
        step(1);
        for (int k = 0; k < 15; k++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("c4 sig k=%0d c=%0d", k, c), sig4, s4[14-k]);
                chk($sformatf("c4 busy k=%0d c=%0d", k, c), busy4, 1'b1);
                chk($sformatf("c4 done k=%0d c=%0d", k, c), done4, 1'b0);
                v4   = (c % 2) == 1;
                dat4 = 8'($urandom);
                step(1);
            end
        end
        chk("c4 end done", done4, 1'b1);
        chk("c4 end busy", busy4, 1'b0);
        chk("c4 end sig", sig4, 1'b0);
        v4 = 1'b0;
        step(1);
        chk("c4 done drops", done4, 1'b0);
        chk("c4 idle ready", rdy4, 1'b1);
        step(2);

        // Reset in the middle of an 8'hFF frame.
        v1 = 1'b1; dat1 = 8'hFF;
        step(1);
        v1 = 1'b0;
        step(7);
        chk("mid k=7 sig", sig1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst sig", sig1, 1'b0);
        chk("mid rst busy", busy1, 1'b0);
        chk("mid rst ready", rdy1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("mid rst done %0d", i), done1, 1'b0);
        end
        rst_n = 1'b1;
        step(1);
        chk("post rst busy", busy1, 1'b0);
        frame1(8'h81, 16'h0020, 1'b0);
        step(1);
        chk("81 done drops", done1, 1'b0);
        step(2);

        // Back-to-back with in_valid held; 8'h12 also holds 10010 in its payload.
        frame1(8'h12, 16'h2020, 1'b1);
        frame1(8'h34, 16'h0020, 1'b0);
        step(1);
        chk("b2b done drops", done1, 1'b0);
        chk("b2b idle busy", busy1, 1'b0);
        chk("b2b idle ready", rdy1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
Serial frame transmitter, the sending end of the single-wire sync-pattern link whose receiver detects the 5-bit sync word 10010. It accepts a parallel payload word on a valid/ready handshake. It then emits on `sig` the sync word, the payload MSB-first, and a trailing run of zero gap bits, one bit per bit period. The gap bits return the receiver's detector to its idle state between frames.

Parameters:
DATA_W, 8, payload width in bits (>=1)
SYNC_W, 5, sync word width
SYNC_PAT, 5'b10010, sync word, sent MSB-first
GAP_BITS, 2, trailing zero bits per frame (>=1)
CLKS_PER_BIT, 1, clock cycles each bit is held on `sig` (>=1)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  payload word offered
in_data  input  DATA_W  payload word; sampled only on accept
in_ready  output  1  block can accept; high only in IDLE
sig  output  1  serial line, registered
busy  output  1  frame in progress (SYNC/DATA/GAP)
done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sig=0, busy=0, done=0, in_ready=1. Counters and the shift register are cleared. A frame in flight is dropped with no done pulse. Normal operation resumes on the first edge after rst_n rises.
- States:
  - IDLE: sig=0.
  - SYNC: SYNC_W bits.
  - DATA: DATA_W bits.
  - GAP: GAP_BITS zero bits.
- in_ready is 1 exactly when state==IDLE; it is decoded from the state register with no combinational path from in_valid.
- Accept: occurs at edge E0 when in_valid && in_ready. in_data is latched into the shift register. After E0: state=SYNC, busy=1, sig=SYNC_PAT[SYNC_W-1].
- Bit stream: S = SYNC_PAT (MSB first), then in_data (MSB first), then GAP_BITS zeros. Total N = SYNC_W+DATA_W+GAP_BITS bits.
- After edge E0+k*CLKS_PER_BIT, for 0<=k<N: sig = S[k], held for CLKS_PER_BIT cycles.
- Bit-period timing uses a divider counter, 0..CLKS_PER_BIT-1. A bit counter selects the current bit within the state. Transitions: SYNC->DATA->GAP->IDLE at bit-count terminal values.
- After edge E0+N*CLKS_PER_BIT: state=IDLE, sig=0, busy=0, in_ready=1, done=1 for exactly one cycle.
- The earliest next accept is on the edge that ends the done cycle. Minimum frame-to-frame spacing is N*CLKS_PER_BIT+1 cycles.
- in_valid and in_data are ignored while busy. Changes to in_data after accept have no effect on the frame.
- No bit stuffing. A payload containing 10010, or forming it across the sync/payload boundary, produces an extra receiver match. This is expected behaviour; payload framing is the user's responsibility.
- With CLKS_PER_BIT=1, sig feeding the receiver directly raises its match output for one cycle. That cycle is the one following the cycle in which the last sync bit is on sig.

Decomposition:
- Shared package pattern_pkg holds:
  - SYNC_PAT and SYNC_W, shared with the receiver so both ends use one definition.
  - The tx state encoding (IDLE, SYNC, DATA, GAP as localparams, 2 bits).
- One sub-module: bit_timer, the CLKS_PER_BIT divider. It produces a one-cycle bit_tick and restarts on accept. Everything else stays in pattern_tx.

Test Plan:
1. Reset: rst_n=0 during arbitrary activity -> sig=0, busy=0, done=0, in_ready=1 immediately, without waiting for a clock edge.
2. CLKS_PER_BIT=1, accept in_data=8'hA5 -> sig over the next 15 cycles is 1,0,0,1,0,1,0,1,0,0,1,0,1,0,0. done=1 in cycle 16 after accept, and busy is high for exactly 15 cycles.
3. Loopback into the receiver, CLKS_PER_BIT=1:
   - in_data=8'h00 -> receiver match pulses exactly once, one cycle after the last sync bit.
   - in_data=8'hA5 -> two pulses; the second comes from the payload, per the no-stuffing rule.
4. CLKS_PER_BIT=4, in_data=8'h3C -> each bit is held 4 cycles and the frame lasts 60 cycles. in_valid pulses and in_data changes during busy cause no change to sig.
5. Reset mid-frame: accept 8'hFF, drop rst_n in cycle 7 -> sig=0 asynchronously and no done pulse. After release, accepting 8'h81 produces a correct full frame.
6. Back-to-back: hold in_valid=1 with 8'h12 then 8'h34 -> in_ready is high only in IDLE. The second accept occurs on the edge ending the first done cycle, and two complete frames are emitted in order.
